adc_trigger_capture: RTL and testbench



---
 rtl/adc_trigger_capture.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_adc_trigger_capture.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_trigger_capture.sv
// Trigger-qualified multichannel sample capture into a circular RAM, read back as a byte stream.
// Define ADC_CAP_HEADER_EN to prefix each record with a 4-byte header (A5, NUM_CH, pre_trig hi/lo).
module adc_trigger_capture #(
    parameter int NUM_CH   = 5,
    parameter int SAMPLE_W = 16,
    parameter int DEPTH    = 1024
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NUM_CH*SAMPLE_W-1:0]                 din,
    input  logic                                       din_valid,
    input  logic                                       arm,
    input  logic                                       abort,
    input  logic                                       force_trig,
    input  logic                                       trig_mode,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] trig_ch,
    input  logic [SAMPLE_W-1:0]                        trig_level,
    input  logic [$clog2(DEPTH)-1:0]                   pre_trig,
    output logic [7:0]                                 dout,
    output logic                                       dout_valid,
    input  logic                                       dout_ready,
    output logic                                       dout_last,
    output logic                                       busy,
    output logic                                       triggered
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DW  = NUM_CH * SAMPLE_W;
    localparam int BPC = (SAMPLE_W + 7) / 8;
    localparam int BPS = NUM_CH * BPC;
    localparam int BW  = (BPS > 1) ? $clog2(BPS) : 1;

    typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, READ} state_t;
    state_t state;

    logic [DW-1:0]       mem [DEPTH];
    logic [DW-1:0]       ram_q;

    logic [AW-1:0]       pt_q;
    logic                mode_q;
    logic [CW-1:0]       tch_q;
    logic [SAMPLE_W-1:0] lvl_q;

    logic [AW-1:0]       wr_addr;
    logic [AW-1:0]       fill_cnt;
    logic [AW:0]         post_cnt;
    logic [AW-1:0]       trig_addr;
    logic [SAMPLE_W-1:0] prev;
    logic                prev_valid;

    logic [AW-1:0]       rd_addr;
    logic [AW:0]         rd_cnt;
    logic                q_valid;
    logic                q_last;
    logic [DW-1:0]       sbuf;
    logic                s_valid;
    logic                s_last;
    logic [BW-1:0]       bidx;

    logic [SAMPLE_W-1:0] cur;
    logic                capturing;
    logic                wr_en;
    logic                thr_hit;
    logic                trig_evt;
    logic [AW:0]         need;
    logic                in_read;
    logic                out_free;
    logic                s_take;
    logic                word_done;
    logic                s_load;
    logic                rd_issue;
    logic                byte_last;
    logic [7:0]          sel_byte;
    logic [BPC*8-1:0]    ext [NUM_CH];
    logic [7:0]          sbytes [BPS];

    always_comb begin
        cur = din[SAMPLE_W-1:0];
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (tch_q == CW'(c)) cur = din[c*SAMPLE_W +: SAMPLE_W];
        end
    end

    assign capturing = (state == FILL) || (state == ARMED) || (state == POST);
    assign wr_en     = capturing && din_valid;
    assign thr_hit   = mode_q && din_valid && prev_valid &&
                       ($signed(prev) < $signed(lvl_q)) && ($signed(cur) >= $signed(lvl_q));
    assign trig_evt  = (state == ARMED) && (force_trig || thr_hit);
    assign need      = (AW+1)'(DEPTH) - {1'b0, pt_q};
    assign busy      = (state != IDLE);

    // Each sample is split into zero-extended, MSB-first bytes, ch0 first.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ext[c] = '0;
            ext[c][SAMPLE_W-1:0] = sbuf[c*SAMPLE_W +: SAMPLE_W];
            for (int unsigned b = 0; b < BPC; b++) begin
                sbytes[c*BPC + b] = ext[c][(BPC-1-b)*8 +: 8];
            end
        end
    end

    // Readout pipeline: ram_q prefetches the next sample while sbuf is being serialised,
    // so the 1-cycle RAM latency never starves the byte output.
    assign in_read  = (state == READ);
    assign out_free = !dout_valid || dout_ready;

`ifdef ADC_CAP_HEADER_EN
    logic [2:0]  hdr_cnt;
    logic        hdr_active;
    logic [15:0] pt16;
    logic [7:0]  hdr_byte;

    assign hdr_active = (hdr_cnt != 3'd4);
    assign pt16       = 16'(pt_q);
    always_comb begin
        case (hdr_cnt[1:0])
            2'd0:    hdr_byte = 8'hA5;
            2'd1:    hdr_byte = 8'(NUM_CH);
            2'd2:    hdr_byte = pt16[15:8];
            default: hdr_byte = pt16[7:0];
        endcase
    end
    assign s_take    = in_read && out_free && (hdr_active || s_valid);
    assign word_done = s_take && !hdr_active && (bidx == BW'(BPS-1));
    assign sel_byte  = hdr_active ? hdr_byte : sbytes[bidx];
`else
    assign s_take    = in_read && out_free && s_valid;
    assign word_done = s_take && (bidx == BW'(BPS-1));
    assign sel_byte  = sbytes[bidx];
`endif

    assign s_load    = in_read && q_valid && (!s_valid || word_done);
    assign rd_issue  = in_read && (rd_cnt != (AW+1)'(DEPTH)) && (!q_valid || s_load);
    assign byte_last = word_done && s_last;

    always_ff @(posedge clk) begin
        if (wr_en)    mem[wr_addr] <= din;
        if (rd_issue) ram_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pt_q       <= '0;
            mode_q     <= 1'b0;
            tch_q      <= '0;
            lvl_q      <= '0;
            wr_addr    <= '0;
            fill_cnt   <= '0;
            post_cnt   <= '0;
            trig_addr  <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            rd_addr    <= '0;
            rd_cnt     <= '0;
            q_valid    <= 1'b0;
            q_last     <= 1'b0;
            sbuf       <= '0;
            s_valid    <= 1'b0;
            s_last     <= 1'b0;
            bidx       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            triggered  <= 1'b0;
`ifdef ADC_CAP_HEADER_EN
            hdr_cnt    <= '0;
`endif
        end else begin
            if (wr_en) begin
                wr_addr    <= wr_addr + 1'b1;
                prev       <= cur;
                prev_valid <= 1'b1;
            end

            if (rd_issue) begin
                rd_addr <= rd_addr + 1'b1;
                rd_cnt  <= rd_cnt + 1'b1;
                q_valid <= 1'b1;
                q_last  <= (rd_cnt == (AW+1)'(DEPTH-1));
            end else if (s_load) begin
                q_valid <= 1'b0;
            end

            if (s_take) begin
                dout       <= sel_byte;
                dout_valid <= 1'b1;
                dout_last  <= byte_last;
`ifdef ADC_CAP_HEADER_EN
                if (hdr_active) begin
                    hdr_cnt <= hdr_cnt + 1'b1;
                end else
`endif
                if (word_done) begin
                    bidx    <= '0;
                    s_valid <= 1'b0;
                end else begin
                    bidx <= bidx + 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
            end

            if (s_load) begin
                sbuf    <= ram_q;
                s_last  <= q_last;
                s_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (arm) begin
                        pt_q       <= pre_trig;
                        mode_q     <= trig_mode;
                        tch_q      <= trig_ch;
                        lvl_q      <= trig_level;
                        wr_addr    <= '0;
                        fill_cnt   <= '0;
                        post_cnt   <= '0;
                        prev_valid <= 1'b0;
                        triggered  <= 1'b0;
                        state      <= (pre_trig == '0) ? ARMED : FILL;
                    end
                end
                FILL: begin
                    if (din_valid) begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt == pt_q - 1'b1) state <= ARMED;
                    end
                end
                ARMED: begin
                    // A force without a valid sample makes the next valid sample the trigger sample.
                    if (trig_evt) begin
                        trig_addr <= wr_addr;
                        triggered <= 1'b1;
                        if (din_valid && (need == (AW+1)'(1))) begin
                            state   <= READ;
                            rd_addr <= wr_addr - pt_q;
                        end else begin
                            state <= POST;
                        end
                        post_cnt <= din_valid ? (AW+1)'(1) : '0;
                        rd_cnt   <= '0;
                        q_valid  <= 1'b0;
                        s_valid  <= 1'b0;
                        bidx     <= '0;
`ifdef ADC_CAP_HEADER_EN
                        hdr_cnt  <= '0;
`endif
                    end
                end
                POST: begin
                    if (din_valid) begin
                        post_cnt <= post_cnt + 1'b1;
                        if (post_cnt + 1'b1 == need) begin
                            state   <= READ;
                            rd_addr <= trig_addr - pt_q;
                        end
                    end
                end
                READ: begin
                    if (dout_valid && dout_ready && dout_last) begin
                        state     <= IDLE;
                        triggered <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (abort) begin
                state      <= IDLE;
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
                triggered  <= 1'b0;
                q_valid    <= 1'b0;
                s_valid    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Directed scoreboard bench for adc_trigger_capture (NUM_CH=2, SAMPLE_W=16, DEPTH=16).
// Works with or without ADC_CAP_HEADER_EN defined.
module tb_adc_trigger_capture;

    localparam int NCH = 2;
    localparam int SW  = 16;
    localparam int D   = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH*SW-1:0] din = '0;
    logic              din_valid = 1'b0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic              force_trig = 1'b0;
    logic              trig_mode = 1'b0;
    logic              trig_ch = 1'b0;
    logic [SW-1:0]     trig_level = '0;
    logic [3:0]        pre_trig = '0;
    logic [7:0]        dout;
    logic              dout_valid;
    logic              dout_ready = 1'b0;
    logic              dout_last;
    logic              busy;
    logic              triggered;

    int checks = 0;
    int errors = 0;
    logic [8:0]  sb[$];
    logic [31:0] hist[$];

    always #5 clk = ~clk;

    adc_trigger_capture #(.NUM_CH(NCH), .SAMPLE_W(SW), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .arm(arm),
        .abort(abort), .force_trig(force_trig), .trig_mode(trig_mode), .trig_ch(trig_ch),
        .trig_level(trig_level), .pre_trig(pre_trig), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy), .triggered(triggered)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Settings are scrambled right after arm: the DUT must use the latched values.
    task automatic do_arm(input int pt, input bit mode, input bit ch, input int lvl);
        pre_trig = 4'(pt); trig_mode = mode; trig_ch = ch; trig_level = 16'(lvl);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        pre_trig = 4'hA; trig_mode = ~mode; trig_ch = ~ch; trig_level = 16'd7;
        hist.delete();
    endtask

    task automatic send(input logic [15:0] c0, input logic [15:0] c1, input bit frc, input int gap);
        din = {c1, c0}; din_valid = 1'b1; force_trig = frc;
        hist.push_back({c1, c0});
        @(negedge clk);
        din_valid = 1'b0; force_trig = 1'b0;
        repeat (gap) begin
            din = $urandom;
            @(negedge clk);
        end
    endtask

    task automatic expect_record(input int t, input int pt);
        logic [31:0] w;
        logic [15:0] v;
`ifdef ADC_CAP_HEADER_EN
        logic [15:0] p;
        p = 16'(pt);
        sb.push_back({1'b0, 8'hA5});
        sb.push_back({1'b0, 8'(NCH)});
        sb.push_back({1'b0, p[15:8]});
        sb.push_back({1'b0, p[7:0]});
`endif
        for (int s = 0; s < D; s++) begin
            w = hist[t - pt + s];
            for (int c = 0; c < NCH; c++) begin
                v = w[c*16 +: 16];
                sb.push_back({1'b0, v[15:8]});
                sb.push_back({(s == D-1) && (c == NCH-1), v[7:0]});
            end
        end
    endtask

    task automatic drain(input bit rnd, input int stop_after);
        int n;
        int cyc;
        bit hold;
        logic [7:0] held;
        n = 0; cyc = 0; hold = 1'b0; held = '0;
        while (sb.size() > 0 && n < stop_after && cyc < 2000) begin
            if (hold) begin
                chk("hold_valid", dout_valid, 1'b1);
                chk("hold_data", dout, held);
            end
            dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (dout_valid && dout_ready) begin
                chk("byte", {dout_last, dout}, sb.pop_front());
                n++;
            end
            hold = dout_valid && !dout_ready;
            held = dout;
            @(negedge clk);
            cyc++;
        end
        dout_ready = 1'b0;
    endtask

    initial begin
        int seen;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_last", dout_last, 1'b0);
        chk("rst_trig", triggered, 1'b0);
        chk("rst_dout", dout, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Force trigger at sample 20 (a force during FILL is ignored), sustained ready.
        do_arm(4, 1'b0, 1'b0, 0);
        chk("arm_busy", busy, 1'b1);
        for (int i = 0; i < 32; i++) begin
            if (i == 20) chk("pre_trig_flag", triggered, 1'b0);
            send(16'(i), 16'($urandom), (i == 1) || (i == 20), 0);
        end
        chk("post_trig_flag", triggered, 1'b1);
        expect_record(20, 4);
        drain(1'b0, 100000);
        chk("t1_left", sb.size(), 0);
        chk("t1_idle", busy, 1'b0);
        chk("t1_trig_clr", triggered, 1'b0);

        // Signed threshold on ch1: crossing inside FILL and a negative sample must not trigger.
        do_arm(4, 1'b1, 1'b1, 100);
        begin
            logic [15:0] seq [8];
            seq = '{16'd90, 16'd50, 16'd120, 16'd90, 16'hFFF0, 16'd90, 16'd95, 16'd100};
            for (int i = 0; i < 19; i++)
                send(16'(i + 256), (i < 8) ? seq[i] : 16'($urandom), 1'b0, 0);
        end
        chk("thr_trig", triggered, 1'b1);
        expect_record(7, 4);
        drain(1'b0, 100000);
        chk("t2_left", sb.size(), 0);

        // Same as the first record but with din_valid gaps and random ready.
        do_arm(4, 1'b0, 1'b0, 0);
        for (int i = 0; i < 32; i++)
            send(16'(i), 16'($urandom), (i == 1) || (i == 20), (i % 3 == 0) ? 2 : 0);
        expect_record(20, 4);
        drain(1'b1, 100000);
        chk("t3_left", sb.size(), 0);
        chk("t3_idle", busy, 1'b0);

        // Abort during POST, abort beating arm, then a pre_trig=0 threshold record.
        do_arm(4, 1'b0, 1'b0, 0);
        for (int i = 0; i < 9; i++) send(16'(i), 16'(i), i == 6, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_trig", triggered, 1'b0);
        arm = 1'b1; abort = 1'b1;
        @(negedge clk);
        arm = 1'b0; abort = 1'b0;
        chk("abort_wins", busy, 1'b0);
        dout_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            if (dout_valid) seen++;
            @(negedge clk);
        end
        dout_ready = 1'b0;
        chk("abort_no_bytes", seen, 0);
        do_arm(0, 1'b1, 1'b0, 100);
        send(16'd150, 16'd1, 1'b0, 0);
        send(16'd50, 16'd2, 1'b0, 0);
        for (int i = 2; i < 18; i++) send((i == 2) ? 16'd120 : 16'($urandom), 16'(i), 1'b0, 0);
        expect_record(2, 0);
        drain(1'b1, 100000);
        chk("t4_left", sb.size(), 0);

        // Reset in the middle of READ.
        do_arm(4, 1'b0, 1'b0, 0);
        for (int i = 0; i < 32; i++) send(16'(i), 16'(i * 7), i == 20, 0);
        expect_record(20, 4);
        drain(1'b0, 10);
        rst_n = 1'b0;
        #1;
        chk("rst_read_valid", dout_valid, 1'b0);
        chk("rst_read_busy", busy, 1'b0);
        chk("rst_read_trig", triggered, 1'b0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        dout_ready = 1'b1;
        seen = 0;
        repeat (30) begin
            if (dout_valid) seen++;
            @(negedge clk);
        end
        chk("rst_no_bytes", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
